check_result_monitor: RTL and testbench

Downstream consumer of the value checker's result output (valid/2-bit check code). It turns each new result into one event, keeps saturating per-code event counters, buffers recent results with a timestamp in a small FIFO for software or bench readout, and raises a sticky alarm after a run of consecutive failures.

---
 rtl/check_result_monitor.sv | 160 ++++++++++++++++
 tb/tb_check_result_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/check_result_monitor.sv
// Consumes checker results: one event per valid rising edge, saturating per-code counters,
// a small result FIFO and a sticky fail-run alarm. Define RESULT_MONITOR_TS_EN to timestamp entries.
module check_result_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned FAIL_LIMIT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             res_valid_i,
  input  logic [1:0]       res_code_i,
  input  logic             pop_i,
  output logic             rd_valid_o,
  output logic [1:0]       rd_code_o,
  output logic [TS_W-1:0]  rd_ts_o,
  output logic             full_o,
  output logic             overflow_o,
  input  logic [1:0]       cnt_sel_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             alarm_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PW    = AW + 1;
  localparam logic [7:0]  LIMIT = 8'(FAIL_LIMIT);

  typedef enum logic [1:0] {RUN_OK, RUN_FAIL, ALARM} state_e;

  logic             res_valid_q;
  logic             ev;
  logic             is_fail;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             empty, full, do_push, do_pop;
  logic             overflow_q;
  logic [1:0]       code_mem [DEPTH];
  logic [CNT_W-1:0] cnt_q [4];
  state_e           state_q, state_d;
  logic [7:0]       run_q, run_d;

  // An event is the rising edge of valid; a clear swallows any coincident event.
  assign ev      = res_valid_i & ~res_valid_q & ~clear_i;
  assign is_fail = (res_code_i != 2'd0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) res_valid_q <= 1'b0;
    else        res_valid_q <= res_valid_i;
  end

  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop_i & ~empty & ~clear_i;
  assign do_push = ev & (~full | do_pop);

  // FIFO pointers and sticky overflow; a simultaneous pop makes room for a push into a full FIFO.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (ev && full && !do_pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) code_mem[wr_idx] <= res_code_i;
  end

`ifdef RESULT_MONITOR_TS_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       ts_q <= '0;
    else if (clear_i) ts_q <= '0;
    else              ts_q <= ts_q + TS_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (do_push) ts_mem[wr_idx] <= ts_q;
  end

  assign rd_ts_o = empty ? '0 : ts_mem[rd_idx];
`else
  assign rd_ts_o = '0;
`endif

  // Per-code counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else if (ev && (cnt_q[res_code_i] != '1)) begin
      cnt_q[res_code_i] <= cnt_q[res_code_i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN_OK;
      run_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Fail-run tracking; ALARM is only left through clear or reset.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (clear_i) begin
      state_d = RUN_OK;
      run_d   = 8'd0;
    end else if (ev) begin
      case (state_q)
        RUN_OK: begin
          if (is_fail) begin
            run_d   = 8'd1;
            state_d = (LIMIT == 8'd1) ? ALARM : RUN_FAIL;
          end
        end
        RUN_FAIL: begin
          if (is_fail) begin
            run_d = run_q + 8'd1;
            if ((run_q + 8'd1) == LIMIT) state_d = ALARM;
          end else begin
            run_d   = 8'd0;
            state_d = RUN_OK;
          end
        end
        ALARM:   state_d = ALARM;
        default: begin
          state_d = RUN_OK;
          run_d   = 8'd0;
        end
      endcase
    end
  end

  assign rd_valid_o = ~empty;
  assign rd_code_o  = empty ? 2'b00 : code_mem[rd_idx];
  assign full_o     = full;
  assign overflow_o = overflow_q;
  assign cnt_o      = cnt_q[cnt_sel_i];
  assign alarm_o    = (state_q == ALARM);

endmodule

// File: tb/tb_check_result_monitor.sv
// Directed bench for check_result_monitor (CNT_W=4, DEPTH=4, FAIL_LIMIT=3).
module tb_check_result_monitor;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TS_W  = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             clear_i, res_valid_i, pop_i;
  logic [1:0]       res_code_i, cnt_sel_i;
  logic             rd_valid_o, full_o, overflow_o, alarm_o;
  logic [1:0]       rd_code_o;
  logic [TS_W-1:0]  rd_ts_o;
  logic [CNT_W-1:0] cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  check_result_monitor #(.CNT_W(CNT_W), .DEPTH(4), .TS_W(TS_W), .FAIL_LIMIT(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .res_valid_i(res_valid_i),
    .res_code_i(res_code_i), .pop_i(pop_i), .rd_valid_o(rd_valid_o), .rd_code_o(rd_code_o),
    .rd_ts_o(rd_ts_o), .full_o(full_o), .overflow_o(overflow_o), .cnt_sel_i(cnt_sel_i),
    .cnt_o(cnt_o), .alarm_o(alarm_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       clr, v;
    logic [1:0] code;
    logic       pop;
    logic [1:0] sel;
    logic       rv;
    logic [1:0] rc;
    logic       full, ovf;
    logic [3:0] cnt;
    logic       alarm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic clr, v, input logic [1:0] code, input logic pop,
                     input logic [1:0] sel, input logic rv, input logic [1:0] rc,
                     input logic full, ovf, input logic [3:0] cnt, input logic alarm);
    vec_t r;
    r = '{clr, v, code, pop, sel, rv, rc, full, ovf, cnt, alarm};
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic clr, v, input logic [1:0] code, input logic pop,
                       input logic [1:0] sel);
    clear_i = clr; res_valid_i = v; res_code_i = code; pop_i = pop; cnt_sel_i = sel;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rd_valid"}, 32'(rd_valid_o), 0);
    chk({tag, " rd_code"},  32'(rd_code_o),  0);
    chk({tag, " rd_ts"},    32'(rd_ts_o),    0);
    chk({tag, " full"},     32'(full_o),     0);
    chk({tag, " overflow"}, 32'(overflow_o), 0);
    chk({tag, " cnt"},      32'(cnt_o),      0);
    chk({tag, " alarm"},    32'(alarm_o),    0);
  endtask

  initial begin
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Test 1: valid held high 10 cycles -> single event
    for (int i = 0; i < 3; i++) add(0,1,0,0,0, 1,0,0,0,1,0);
    add(0,1,0,0,1, 1,0,0,0,0,0);
    add(0,1,0,0,2, 1,0,0,0,0,0);
    add(0,1,0,0,3, 1,0,0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,1,0,0,0, 1,0,0,0,1,0);
    add(0,0,0,1,0, 0,0,0,0,1,0);
    // Test 2: codes 1,2,0,3 then ordered pops
    add(1,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,0,1, 1,1,0,0,1,0);
    add(0,0,1,0,1, 1,1,0,0,1,0);
    add(0,1,2,0,2, 1,1,0,0,1,0);
    add(0,0,2,0,2, 1,1,0,0,1,0);
    add(0,1,0,0,0, 1,1,0,0,1,0);
    add(0,0,0,0,0, 1,1,0,0,1,0);
    add(0,1,3,0,3, 1,1,1,0,1,0);
    add(0,0,0,1,3, 1,2,0,0,1,0);
    add(0,0,0,1,3, 1,0,0,0,1,0);
    add(0,0,0,1,3, 1,3,0,0,1,0);
    add(0,0,0,1,3, 0,0,0,0,1,0);
    add(0,0,0,1,3, 0,0,0,0,1,0);
    // Test 3: fill, push+pop while full, overflow, drain
    add(1,0,0,0,0, 0,0,0,0,0,0);
    for (int i = 1; i <= 4; i++) begin
      add(0,1,0,0,0, 1,0,(i == 4),0,4'(i),0);
      add(0,0,0,0,0, 1,0,(i == 4),0,4'(i),0);
    end
    add(0,1,0,1,0, 1,0,1,0,5,0);
    add(0,0,0,0,0, 1,0,1,0,5,0);
    add(0,1,0,0,0, 1,0,1,1,6,0);
    add(0,0,0,0,0, 1,0,1,1,6,0);
    for (int i = 0; i < 3; i++) add(0,0,0,1,0, 1,0,0,1,6,0);
    add(0,0,0,1,0, 0,0,0,1,6,0);
    // Test 4: fails 1,3, pass, fails 2,2,1 -> alarm
    add(1,0,0,0,1, 0,0,0,0,0,0);
    add(0,1,1,0,1, 1,1,0,0,1,0);
    add(0,0,0,1,1, 0,0,0,0,1,0);
    add(0,1,3,0,1, 1,3,0,0,1,0);
    add(0,0,0,1,1, 0,0,0,0,1,0);
    add(0,1,0,0,1, 1,0,0,0,1,0);
    add(0,0,0,1,1, 0,0,0,0,1,0);
    add(0,1,2,0,1, 1,2,0,0,1,0);
    add(0,0,0,1,1, 0,0,0,0,1,0);
    add(0,1,2,0,1, 1,2,0,0,1,0);
    add(0,0,0,1,1, 0,0,0,0,1,0);
    add(0,1,1,0,1, 1,1,0,0,2,1);
    add(0,0,0,1,1, 0,0,0,0,2,1);
    add(0,1,0,0,1, 1,0,0,0,2,1);
    add(0,0,0,1,1, 0,0,0,0,2,1);
    add(1,0,0,0,1, 0,0,0,0,0,0);
    // Test 6: event coincident with clear, valid held high afterwards
    add(0,1,1,0,1, 1,1,0,0,1,0);
    add(0,0,0,0,1, 1,1,0,0,1,0);
    add(1,1,1,0,1, 0,0,0,0,0,0);
    add(0,1,1,0,1, 0,0,0,0,0,0);
    add(0,1,1,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,1, 0,0,0,0,0,0);

    #12;
    chk_zero("reset");
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].clr, tbl[i].v, tbl[i].code, tbl[i].pop, tbl[i].sel);
      @(posedge clk_i);
      #1;
      chk($sformatf("row%0d rd_valid", i), 32'(rd_valid_o), 32'(tbl[i].rv));
      chk($sformatf("row%0d rd_code", i),  32'(rd_code_o),  32'(tbl[i].rc));
      chk($sformatf("row%0d full", i),     32'(full_o),     32'(tbl[i].full));
      chk($sformatf("row%0d overflow", i), 32'(overflow_o), 32'(tbl[i].ovf));
      chk($sformatf("row%0d cnt", i),      32'(cnt_o),      32'(tbl[i].cnt));
      chk($sformatf("row%0d alarm", i),    32'(alarm_o),    32'(tbl[i].alarm));
`ifndef RESULT_MONITOR_TS_EN
      chk($sformatf("row%0d rd_ts", i),    32'(rd_ts_o),    0);
`endif
      @(negedge clk_i);
    end

    // Test 5: 17 events of code 2 saturate a 4-bit counter at 15
    for (int i = 0; i < 17; i++) begin
      drive(0, 1, 2, 1, 2);
      @(posedge clk_i); #1;
      chk($sformatf("sat ev%0d cnt", i), 32'(cnt_o), (i + 1 > 15) ? 15 : i + 1);
      @(negedge clk_i);
      drive(0, 0, 0, 1, 2);
      @(posedge clk_i);
      @(negedge clk_i);
    end

`ifdef RESULT_MONITOR_TS_EN
    // Timestamps: clear zeroes ts, events on alternate cycles store 0,2,4,6
    drive(1, 0, 0, 0, 0);
    @(posedge clk_i); @(negedge clk_i);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 2'(k), 0, 0);
      @(posedge clk_i); @(negedge clk_i);
      drive(0, 0, 0, 0, 0);
      @(posedge clk_i); @(negedge clk_i);
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ts pop%0d rd_ts", k), 32'(rd_ts_o), 2 * k);
      chk($sformatf("ts pop%0d rd_code", k), 32'(rd_code_o), k);
      drive(0, 0, 0, 1, 0);
      @(posedge clk_i); @(negedge clk_i);
    end
    chk("ts drained rd_valid", 32'(rd_valid_o), 0);
`endif

    // Asynchronous reset mid-run, then valid high on the first edge after release
    drive(1, 0, 0, 0, 1);
    @(posedge clk_i); @(negedge clk_i);
    drive(0, 1, 1, 0, 1);
    @(posedge clk_i); #1;
    chk("pre-rst cnt", 32'(cnt_o), 1);
    #2 rst_i = 1'b0;
    #1;
    chk_zero("async rst");
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(0, 1, 3, 0, 3);
    @(posedge clk_i); #1;
    chk("post-rst cnt", 32'(cnt_o), 1);
    chk("post-rst rd_code", 32'(rd_code_o), 3);
    @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
